sram_arbiter: RTL

Shares the single SRAM controller between the CPU's instruction-fetch (IF) port and data-memory (MEM) port. Each port issues one access at a time and holds it until it receives a one-cycle ack. The arbiter grants round-robin on contention, drives the controller's op/addr/data/mask lines stable for a fixed access window, captures read data, and produces the pipeline stall signals. It sits between the pipeline memory stages and `sram_controller`.

---
 rtl/sram_arbiter_pkg.sv | 25 ++
 rtl/sram_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: data/address words, FSM states and
// requester identities, plus the round-robin pick used at arbitration.
package sram_arbiter_pkg;

  typedef logic [31:0] Word_t;
  typedef logic [19:0] Ram_addr_t;
  typedef logic        Bit_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} Arb_state_t;
  typedef enum logic       {PORT_IF, PORT_MEM}              Arb_port_t;

  // A single requester wins outright; on a tie the port that did not win last time goes.
  function automatic Arb_port_t pick_port(input Bit_t if_req, input Bit_t mem_req,
                                          input Arb_port_t last);
    Arb_port_t p;
    p = PORT_IF;
    if (if_req && mem_req) begin
      if (last == PORT_IF) p = PORT_MEM;
    end else if (mem_req) begin
      p = PORT_MEM;
    end
    return p;
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between the IF and MEM
// ports; holds each access for ACCESS_CYCLES, then a recovery/ack cycle.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ACCESS_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  Ram_addr_t   if_addr,
  output Word_t       if_rdata,
  output logic        if_ack,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_we,
  input  Ram_addr_t   mem_addr,
  input  Word_t       mem_wdata,
  input  logic [3:0]  mem_be,
  output Word_t       mem_rdata,
  output logic        mem_ack,
  output logic        mem_stall,
  output logic        sram_read_op,
  output logic        sram_write_op,
  output Ram_addr_t   sram_addr,
  output Word_t       sram_wdata,
  input  Word_t       sram_rdata,
  output logic [3:0]  sram_byte_mask
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);

  Arb_state_t         state;
  Arb_port_t          grant;
  Arb_port_t          last_grant;
  Arb_port_t          pick;
  logic [CNT_W-1:0]   cnt;

  assign pick = pick_port(if_req, mem_req, last_grant);

  // Stalls are combinational so the pipeline releases in the same cycle the ack arrives.
  assign if_stall  = if_req & ~if_ack;
  assign mem_stall = mem_req & ~mem_ack;

  // The sram_* registers double as the latched request: they are loaded once at
  // grant and never look at the requester inputs again until the next grant.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values; the async reset also drops the ops
  // immediately, aborting an in-flight access without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ARB_IDLE;
      grant          <= PORT_IF;
      last_grant     <= PORT_MEM;
      cnt            <= '0;
      sram_read_op   <= 1'b0;
      sram_write_op  <= 1'b0;
      sram_addr      <= '0;
      sram_wdata     <= '0;
      sram_byte_mask <= '0;
      if_ack         <= 1'b0;
      mem_ack        <= 1'b0;
      if_rdata       <= '0;
      mem_rdata      <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (if_req || mem_req) begin
            grant      <= pick;
            last_grant <= pick;
            cnt        <= CNT_W'(ACCESS_CYCLES - 1);
            state      <= ARB_ACCESS;
            if (pick == PORT_IF) begin
              sram_read_op   <= 1'b1;
              sram_write_op  <= 1'b0;
              sram_addr      <= if_addr;
              sram_wdata     <= '0;
              sram_byte_mask <= 4'b1111;
            end else begin
              sram_read_op   <= ~mem_we;
              sram_write_op  <= mem_we;
              sram_addr      <= mem_addr;
              sram_wdata     <= mem_wdata;
              sram_byte_mask <= mem_be;
            end
          end
        end

        ARB_ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (sram_read_op) begin
              if (grant == PORT_IF) if_rdata  <= sram_rdata;
              else                  mem_rdata <= sram_rdata;
            end
            sram_read_op   <= 1'b0;
            sram_write_op  <= 1'b0;
            sram_addr      <= '0;
            sram_wdata     <= '0;
            sram_byte_mask <= '0;
            if (grant == PORT_IF) if_ack  <= 1'b1;
            else                  mem_ack <= 1'b1;
            state <= ARB_DONE;
          end
        end

        ARB_DONE: begin
          if_ack  <= 1'b0;
          mem_ack <= 1'b0;
          state   <= ARB_IDLE;
        end

        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
